// File: rtl/mul_seq_ctrl_if.sv
// ============================================================================
// Module   : mul_seq_ctrl_if
// Brief    : Operand/control/result bundle for the 6x6 sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_seq_ctrl_if;
    logic [5:0]  A;
    logic [5:0]  B;
    logic        sw;
    logic        start;
    logic [11:0] led;
    logic        busy;
    logic        done;

    modport master (
        output A, B, sw, start,
        input  led, busy, done
    );

    modport slave (
        input  A, B, sw, start,
        output led, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
// ============================================================================
// Module   : mul_seq_ctrl
// Brief    : Shift-add 6x6 multiplier, one multiplier bit per clock, with
//            unsigned or two's-complement mode and registered busy/done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq_ctrl (
    input  wire logic     clk,
    input  wire logic     reset,
    mul_seq_ctrl_if.slave bus
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RUN       = 2'd1;
    localparam logic [1:0] c_DONE      = 2'd2;
    localparam logic [2:0] c_LAST_ITER = 3'd5;

    logic [1:0]  r_state;
    logic [11:0] r_mcand;
    logic [5:0]  r_mplier;
    logic [11:0] r_acc;
    logic [2:0]  r_iter;
    logic        r_signed;
    logic [11:0] r_led;
    logic        r_busy;
    logic        r_done;

    logic [11:0] w_addend;
    logic [11:0] w_acc_next;

    // In signed mode the multiplier MSB carries weight -32, so it subtracts.
    always_comb begin
        w_addend   = r_mcand << r_iter;
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            if (r_signed && (r_iter == c_LAST_ITER)) begin
                w_acc_next = r_acc - w_addend;
            end else begin
                w_acc_next = r_acc + w_addend;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_iter   <= '0;
            r_signed <= 1'b0;
            r_led    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mcand  <= bus.sw ? {{6{bus.A[5]}}, bus.A} : {6'b0, bus.A};
                        r_mplier <= bus.B;
                        r_signed <= bus.sw;
                        r_acc    <= '0;
                        r_iter   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_iter   <= r_iter + 3'd1;
                    // The last iteration's sum goes straight to the display.
                    if (r_iter == c_LAST_ITER) begin
                        r_led   <= w_acc_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.led  = r_led;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
// ============================================================================
// Module   : tb_mul_seq_ctrl
// Brief    : Self-checking bench for mul_seq_ctrl: vector table, scoreboard
//            queue and hand-written reset / isolation / back-to-back runs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mul_seq_ctrl_if bus ();

    mul_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  a;
        logic [5:0]  b;
        logic        s;
        logic [11:0] exp;
    } vec_t;

    localparam int c_NVEC = 8;

    vec_t        vecs [c_NVEC];
    logic [11:0] sb_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          overlap  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [11:0] model(input logic [5:0] a, input logic [5:0] b, input logic s);
        int p;
        if (s) p = $signed(a) * $signed(b);
        else   p = a * b;
        return p[11:0];
    endfunction

    task automatic start_op(input logic [5:0] a, input logic [5:0] b, input logic s,
                            input logic [11:0] exp);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.sw    = s;
        bus.start = 1'b1;
        sb_q.push_back(exp);
    endtask

    // Runs from the negedge on which start was driven to the first IDLE cycle.
    task automatic finish_op(input string name, input bit jitter);
        int          waits;
        bit          seen;
        logic [11:0] exp_led;
        @(negedge clk);
        bus.start = 1'b0;
        chk({name, "_busy"}, {31'b0, bus.busy}, 32'd1);
        waits = 0;
        seen  = 1'b0;
        while (!seen && waits < 20) begin
            if (jitter) begin
                bus.A     = ~bus.A;
                bus.B     = bus.B + 6'd1;
                bus.sw    = ~bus.sw;
                bus.start = ~bus.start;
            end
            @(negedge clk);
            waits++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) seen = 1'b1;
        end
        chk({name, "_latency"}, waits, 32'd6);
        exp_led = (sb_q.size() > 0) ? sb_q.pop_front() : 12'hxxx;
        chk({name, "_led"}, {20'b0, bus.led}, {20'b0, exp_led});
        if (jitter) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({name, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
        chk({name, "_idle"}, {31'b0, bus.busy}, 32'd0);
        chk({name, "_hold"}, {20'b0, bus.led}, {20'b0, exp_led});
    endtask

    initial begin
        logic [5:0]  ra;
        logic [5:0]  rb;
        logic        rs;
        int          cyc;
        int          pulses;
        int          last;
        int          stable_err;
        logic [11:0] held;

        vecs[0] = '{6'b111111, 6'b111111, 1'b0, 12'hF81};
        vecs[1] = '{6'b011111, 6'b011111, 1'b1, 12'h3C1};
        vecs[2] = '{6'b111111, 6'b000011, 1'b1, 12'hFFD};
        vecs[3] = '{6'b111111, 6'b000011, 1'b0, 12'h0BD};
        vecs[4] = '{6'b100000, 6'b100000, 1'b1, 12'h400};
        vecs[5] = '{6'b100000, 6'b011111, 1'b1, 12'hC20};
        vecs[6] = '{6'b000000, 6'b101101, 1'b0, 12'h000};
        vecs[7] = '{6'b000101, 6'b111111, 1'b1, 12'hFFB};

        reset     = 1'b1;
        bus.A     = '0;
        bus.B     = '0;
        bus.sw    = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("reset_led",  {20'b0, bus.led},  32'd0);
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_done", {31'b0, bus.done}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < c_NVEC; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
            finish_op($sformatf("vec%0d", i), 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            ra = 6'($urandom);
            rb = 6'($urandom);
            rs = 1'(i);
            start_op(ra, rb, rs, model(ra, rb, rs));
            finish_op($sformatf("rand%0d", i), 1'b0);
        end

        // Reset in the middle of RUN, with a nonzero led from the last run.
        @(negedge clk);
        bus.A     = 6'b111111;
        bus.B     = 6'b111111;
        bus.sw    = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrun_reset_led",  {20'b0, bus.led},  32'd0);
        chk("midrun_reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrun_reset_done", {31'b0, bus.done}, 32'd0);
        #1;
        reset     = 1'b0;
        bus.A     = 6'b000111;
        bus.B     = 6'b000101;
        bus.sw    = 1'b0;
        bus.start = 1'b1;
        sb_q.push_back(12'd35);
        finish_op("post_reset", 1'b0);

        // Operand changes and start pulses while the multiply is in flight.
        start_op(6'b011001, 6'b011111, 1'b0, 12'h307);
        finish_op("isolation", 1'b1);

        // Start held high: one operation per 8 cycles, operands change per op.
        @(negedge clk);
        bus.A     = 6'b110011;
        bus.B     = 6'b001101;
        bus.sw    = 1'b1;
        bus.start = 1'b1;
        sb_q.push_back(model(6'b110011, 6'b001101, 1'b1));
        cyc        = 0;
        pulses     = 0;
        last       = -1;
        stable_err = 0;
        held       = '0;
        while (pulses < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 20) bus.start = 1'b0;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                pulses++;
                chk($sformatf("b2b_led%0d", pulses), {20'b0, bus.led},
                    {20'b0, (sb_q.size() > 0) ? sb_q.pop_front() : 12'hxxx});
                if (last >= 0) chk($sformatf("b2b_spacing%0d", pulses), cyc - last, 32'd8);
                last = cyc;
                held = bus.led;
                if (pulses < 3) begin
                    bus.A  = bus.A + 6'd7;
                    bus.B  = bus.B + 6'd11;
                    bus.sw = ~bus.sw;
                    sb_q.push_back(model(bus.A, bus.B, bus.sw));
                end
            end else if (last >= 0 && bus.led !== held) begin
                stable_err++;
            end
        end
        bus.start = 1'b0;
        chk("b2b_pulses", pulses, 32'd3);
        chk("b2b_led_stable", stable_err, 32'd0);
        repeat (3) @(negedge clk);
        chk("b2b_no_extra_op", {31'b0, bus.busy}, 32'd0);

        chk("no_busy_done_overlap", overlap, 32'd0);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential controller and datapath for the 6x6 multiplier behind the board's `A`/`B` switches, `sw` mode switch and 12 `led` outputs. It accepts a start request, latches operands and mode, and computes the product one multiplier bit per clock over six cycles. It then presents the result on `led` with a one-cycle `done` pulse. `sw` selects unsigned (0) or two's-complement signed (1) multiplication.

## Interface
- No parameters; widths fixed: 6-bit operands, 12-bit product, 6 iterations.
- `clk` in 1: single system clock, rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `A` in 6: multiplicand.
- `B` in 6: multiplier.
- `sw` in 1: mode; 0 = unsigned, 1 = signed two's complement.
- `start` in 1: request; sampled only in IDLE.
- `led` out 12: last completed product; reset 12'h000.
- `busy` out 1: high while in RUN; reset 0.
- `done` out 1: one-cycle pulse when `led` has just been updated; reset 0.

## Operation
- States:
  - IDLE → RUN on `start`=1; that edge latches `A`, `B`, `sw` and clears the accumulator and iteration counter.
  - RUN → DONE after the 6th iteration.
  - DONE → IDLE unconditionally.
- Reset state is IDLE.
- Datapath:
  - Multiplicand register is 12 bits: `A` sign-extended when `sw`=1, zero-extended when `sw`=0.
  - Multiplier register is 6 bits, shifted right once per iteration.
  - Accumulator is 12 bits, modulo 2^12.
- Iteration i (i = 0..5), when multiplier bit i is 1:
  - i < 5: accumulator += multiplicand << i.
  - i = 5, unsigned: accumulator += multiplicand << 5.
  - i = 5, signed: accumulator −= multiplicand << 5, since the MSB has weight −32.
  - Multiplier bit 0: no change.
- Result:
  - Unsigned: A×B, 0..3969.
  - Signed: A×B as a 12-bit two's-complement value, −992..1024.
  - Neither mode can overflow.
- `led` loads the accumulator on the RUN→DONE edge and holds it until the next completion or reset.
- Changes on `A`, `B` or `sw` after the start edge do not affect the operation in flight.
- `start` in RUN or DONE is ignored. It is not queued.
- `start` held high continuously: a new operation begins on each return to IDLE, one every 8 cycles.

## Timing
- `start` sampled high at edge t:
  - `busy`=1 from edge t to edge t+6, i.e. 6 cycles.
  - `led` updates at edge t+6.
  - `done`=1 from edge t+6 to edge t+7.
  - IDLE re-entered at edge t+7; earliest next accepted start is edge t+8.
- `busy` and `done` are never high together. Both are registered, not decoded from inputs.
- `reset` asserted at any time, including mid-RUN:
  - Immediately (asynchronously) `led`=0, `busy`=0, `done`=0, state IDLE.
  - The partial result is discarded.
- First `start` is accepted on the first rising edge after `reset` deasserts.

## Test plan
- Reset: assert `reset` mid-RUN → `led`=12'h000, `busy`=0, `done`=0 without a clock edge. After release, `start` is accepted on the next edge.
- Unsigned max: `A`=6'b111111, `B`=6'b111111, `sw`=0, start → after 6 busy cycles `led`=12'hF81 (3969) and `done` pulses once.
- Signed pair: `A`=6'b011111, `B`=6'b011111, `sw`=1 → `led`=12'h3C1 (961). Then `A`=6'b111111, `B`=6'b000011:
  - `sw`=1 → `led`=12'hFFD (−3).
  - `sw`=0 → `led`=12'h0BD (189).
- Signed extremes: `A`=`B`=6'b100000, `sw`=1 → `led`=12'h400 (1024). `A`=6'b100000, `B`=6'b011111, `sw`=1 → `led`=12'hC20 (−992).
- Input isolation: start with `A`=6'b011001, `B`=6'b011111, `sw`=0, then toggle `A`/`B`/`sw` every cycle during RUN and pulse `start` → `led`=12'h307 (775). No second operation starts before IDLE.
- Back-to-back: hold `start`=1 for 20 cycles → `done` pulses at 8-cycle spacing. `led` is stable between pulses, and `busy` never overlaps `done`.
